// File: rtl/mxv_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mxv_seq_ctrl
// Brief    : Matrix-vector array sequencer: pops vector elements, steers the
//            LANES multiply-accumulate lanes, drains results row by row.
// Revision : 1.0 - initial release
// ============================================================================
module mxv_seq_ctrl #(
  parameter int NMAX  = 8,
  parameter int LANES = 4,
  parameter int NW    = $clog2(NMAX + 1),
  parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [NW-1:0]    n,
  input  logic             in_empty,
  input  logic             out_full,
  output logic             pop,
  output logic             push,
  output logic [LW-1:0]    lane_sel,
  output logic [LANES-1:0] lane_en,
  output logic             acc_en,
  output logic             acc_clr,
  output logic [NW-1:0]    row_base,
  output logic [NW-1:0]    col_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_OP    = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [NW:0] c_LANES = (NW + 1)'(LANES);
  localparam logic [NW:0] c_NMAX  = (NW + 1)'(NMAX);

  state_t        r_state, w_state_nxt;
  logic [NW-1:0] r_n, w_n_nxt;
  logic [NW-1:0] r_row_base, w_row_base_nxt;
  logic [NW-1:0] r_col_idx, w_col_idx_nxt;
  logic [LW-1:0] r_lane, w_lane_nxt;
  logic          r_err, w_err_nxt;

  logic [NW:0] w_rows_left, w_active, w_next_base;
  logic        w_n_ok, w_last_lane, w_last_col;

  // Pass arithmetic is one bit wider than the counters so row_base+LANES cannot wrap
  assign w_rows_left = {1'b0, r_n} - {1'b0, r_row_base};
  assign w_active    = (w_rows_left < c_LANES) ? w_rows_left : c_LANES;
  assign w_next_base = {1'b0, r_row_base} + c_LANES;
  assign w_last_lane = ((NW + 1)'(r_lane) == (w_active - 1'b1));
  assign w_last_col  = (r_col_idx == (r_n - 1'b1));
  assign w_n_ok      = (n != '0) && ({1'b0, n} <= c_NMAX);

  always_comb begin
    w_state_nxt    = r_state;
    w_n_nxt        = r_n;
    w_row_base_nxt = r_row_base;
    w_col_idx_nxt  = r_col_idx;
    w_lane_nxt     = r_lane;
    w_err_nxt      = 1'b0;
    pop            = 1'b0;
    push           = 1'b0;
    lane_sel       = '0;
    acc_en         = 1'b0;
    acc_clr        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_n_ok) begin
            w_n_nxt        = n;
            w_row_base_nxt = '0;
            w_col_idx_nxt  = '0;
            w_lane_nxt     = '0;
            w_state_nxt    = S_LOAD;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_LOAD: begin
        pop = ~in_empty;
        if (!in_empty) w_state_nxt = S_OP;
      end
      S_OP: begin
        acc_en  = 1'b1;
        acc_clr = (r_col_idx == '0);
        if (w_last_col) begin
          w_col_idx_nxt = '0;
          w_state_nxt   = S_DRAIN;
        end else begin
          w_col_idx_nxt = r_col_idx + 1'b1;
          w_state_nxt   = S_LOAD;
        end
      end
      S_DRAIN: begin
        lane_sel = r_lane;
        push     = ~out_full;
        if (!out_full) begin
          if (w_last_lane) begin
            w_lane_nxt = '0;
            if (w_next_base >= {1'b0, r_n}) begin
              w_state_nxt = S_DONE;
            end else begin
              w_row_base_nxt = w_next_base[NW-1:0];
              w_state_nxt    = S_LOAD;
            end
          end else begin
            w_lane_nxt = r_lane + 1'b1;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // Abort overrides everything, including the FIFO strobes of this cycle
    if (abort) begin
      w_state_nxt    = S_IDLE;
      w_row_base_nxt = '0;
      w_col_idx_nxt  = '0;
      w_lane_nxt     = '0;
      w_err_nxt      = 1'b0;
      pop            = 1'b0;
      push           = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_n        <= '0;
      r_row_base <= '0;
      r_col_idx  <= '0;
      r_lane     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_n        <= w_n_nxt;
      r_row_base <= w_row_base_nxt;
      r_col_idx  <= w_col_idx_nxt;
      r_lane     <= w_lane_nxt;
      r_err      <= w_err_nxt;
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_en
      assign lane_en[gi] = (r_state != S_IDLE) &&
                           (({1'b0, r_row_base} + (NW + 1)'(gi)) < {1'b0, r_n});
    end
  endgenerate

  assign row_base = r_row_base;
  assign col_idx  = r_col_idx;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign err      = r_err;

endmodule
`default_nettype wire
